core_ctrl: RTL and testbench

Instruction sequencer for the 2D accelerator `core`. It generates the 34-bit `inst` word each cycle to run one full convolution layer; activations and weights must already sit in xmem. Per kernel position it:
- loads weights through L0 into the array,
- streams activations through L0 and executes,
- drains the OFIFO into pmem.

It then accumulates the per-kij psums into final outputs. It replaces the hand-driven instruction stimulus in `core_tb` and sits directly in front of `core.inst`.

---
 rtl/core_pkg.sv | 43 ++++
 rtl/core_ctrl_if.sv | 28 ++
 rtl/core_ctrl_acc_addr_gen.sv | 65 ++++++
 rtl/core_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_core_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core instruction sequencer:
// inst bit positions, the NOP word and the FSM state encoding.
package core_pkg;

  localparam int INST_W = 34;

  localparam int ACC_B  = 33;
  localparam int CENP_B = 32;
  localparam int WENP_B = 31;
  localparam int AP_HI  = 30;
  localparam int AP_LO  = 20;
  localparam int CENX_B = 19;
  localparam int WENX_B = 18;
  localparam int AX_HI  = 17;
  localparam int AX_LO  = 7;
  localparam int OFRD_B = 6;
  localparam int IFWR_B = 5;
  localparam int IFRD_B = 4;
  localparam int L0RD_B = 3;
  localparam int L0WR_B = 2;
  localparam int EXEC_B = 1;
  localparam int LOAD_B = 0;

  localparam logic [INST_W-1:0] NOP =
    (34'd1 << CENP_B) |
    (34'd1 << WENP_B) |
    (34'd1 << CENX_B) |
    (34'd1 << WENX_B);

  typedef enum logic [3:0] {
    IDLE,
    W_L0,
    W_LD,
    W_DRN,
    X_L0,
    X_EX,
    OF_RD,
    AC_RD,
    AC_WR,
    DONE
  } state_t;

endpackage

// File: rtl/core_ctrl_if.sv
// Control-side bundle between the sequencer and the core:
// layer start/ofifo status in, instruction word and status out.
interface core_ctrl_if;
  import core_pkg::*;

  logic              start;
  logic              ofifo_valid;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    input  ofifo_valid,
    output inst,
    output busy,
    output done
  );

  modport slave (
    output start,
    output ofifo_valid,
    input  inst,
    input  busy,
    input  done
  );

endinterface

// File: rtl/core_ctrl_acc_addr_gen.sv
// Psum read address for the accumulation pass: nested kernel
// row/col counters inside nested output row/col counters.
module acc_addr_gen #(
  parameter int k_width = 3,
  parameter int o_width = 4,
  parameter int i_width = 6,
  parameter int len_nij = 36
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        step,
  output logic [10:0] addr
);

  localparam logic [3:0] KL = 4'(k_width - 1);
  localparam logic [3:0] OL = 4'(o_width - 1);

  logic [3:0] krow;
  logic [3:0] kcol;
  logic [3:0] orow;
  logic [3:0] ocol;
  logic [10:0] k;

  // Kernel counters advance every step; the output pixel
  // advances when the whole kernel window has been read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      krow <= '0;
      kcol <= '0;
      orow <= '0;
      ocol <= '0;
    end else if (clear) begin
      krow <= '0;
      kcol <= '0;
      orow <= '0;
      ocol <= '0;
    end else if (step) begin
      if (kcol == KL) begin
        kcol <= '0;
        if (krow == KL) begin
          krow <= '0;
          if (ocol == OL) begin
            ocol <= '0;
            orow <= (orow == OL) ? '0 : orow + 4'd1;
          end else begin
            ocol <= ocol + 4'd1;
          end
        end else begin
          krow <= krow + 4'd1;
        end
      end else begin
        kcol <= kcol + 4'd1;
      end
    end
  end

  always_comb begin
    k = 11'(krow) * 11'(k_width) + 11'(kcol);
    addr = k * 11'(len_nij)
         + (11'(orow) + 11'(krow)) * 11'(i_width)
         + 11'(ocol) + 11'(kcol);
  end

endmodule

// File: rtl/core_ctrl.sv
// Layer sequencer: emits one registered core instruction per
// cycle for weight load, execute, psum drain and accumulation.
module core_ctrl
  import core_pkg::*;
#(
  parameter int col      = 8,
  parameter int row      = 8,
  parameter int len_kij  = 9,
  parameter int len_nij  = 36,
  parameter int len_onij = 16,
  parameter int i_width  = 6,
  parameter int o_width  = 4,
  parameter int k_width  = 3,
  parameter logic [10:0] w_base   = 11'd1024,
  parameter logic [10:0] out_base = 11'd512
) (
  input logic        clk,
  input logic        reset,
  core_ctrl_if.master bus
);

  state_t state;
  state_t state_n;

  logic [6:0] cnt;
  logic [6:0] cnt_n;
  logic [3:0] kij;
  logic [3:0] kij_n;
  logic [4:0] o;
  logic [4:0] o_n;

  logic [INST_W-1:0] inst;
  logic [INST_W-1:0] inst_n;
  logic busy;
  logic done;

  logic clear;
  logic step;
  logic [10:0] acc_a;

  acc_addr_gen #(
    .k_width (k_width),
    .o_width (o_width),
    .i_width (i_width),
    .len_nij (len_nij)
  ) u_acc (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .step  (step),
    .addr  (acc_a)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      kij   <= '0;
      o     <= '0;
      inst  <= NOP;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      kij   <= kij_n;
      o     <= o_n;
      inst  <= inst_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    kij_n   = kij;
    o_n     = o;
    inst_n  = NOP;
    clear   = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = W_L0;
          cnt_n   = '0;
          kij_n   = '0;
          o_n     = '0;
          clear   = 1'b1;
        end
      end
      W_L0: begin
        inst_n[CENX_B] = 1'b0;
        inst_n[AX_HI:AX_LO] = w_base
          + 11'(kij) * 11'(col) + 11'(cnt);
        inst_n[L0WR_B] = 1'b1;
        if (cnt == 7'(col - 1)) begin
          cnt_n   = '0;
          state_n = W_LD;
        end else begin
          cnt_n = cnt + 7'd1;
        end
      end
      W_LD: begin
        inst_n[L0RD_B] = 1'b1;
        inst_n[LOAD_B] = 1'b1;
        if (cnt == 7'(col - 1)) begin
          cnt_n   = '0;
          state_n = W_DRN;
        end else begin
          cnt_n = cnt + 7'd1;
        end
      end
      W_DRN: begin
        if (cnt == 7'(row + col - 1)) begin
          cnt_n   = '0;
          state_n = X_L0;
        end else begin
          cnt_n = cnt + 7'd1;
        end
      end
      X_L0: begin
        inst_n[CENX_B] = 1'b0;
        inst_n[AX_HI:AX_LO] = 11'(cnt);
        inst_n[L0WR_B] = 1'b1;
        if (cnt == 7'(len_nij - 1)) begin
          cnt_n   = '0;
          state_n = X_EX;
        end else begin
          cnt_n = cnt + 7'd1;
        end
      end
      X_EX: begin
        inst_n[L0RD_B] = 1'b1;
        inst_n[EXEC_B] = 1'b1;
        if (cnt == 7'(len_nij - 1)) begin
          cnt_n   = '0;
          state_n = OF_RD;
        end else begin
          cnt_n = cnt + 7'd1;
        end
      end
      OF_RD: begin
        // Without valid data the phase simply waits.
        if (bus.ofifo_valid) begin
          inst_n[OFRD_B] = 1'b1;
          inst_n[CENP_B] = 1'b0;
          inst_n[WENP_B] = 1'b0;
          inst_n[AP_HI:AP_LO] = 11'(kij) * 11'(len_nij)
            + 11'(cnt);
          if (cnt == 7'(len_nij - 1)) begin
            cnt_n = '0;
            if (kij != 4'(len_kij - 1)) begin
              kij_n   = kij + 4'd1;
              state_n = W_L0;
            end else begin
              o_n     = '0;
              clear   = 1'b1;
              state_n = AC_RD;
            end
          end else begin
            cnt_n = cnt + 7'd1;
          end
        end
      end
      AC_RD: begin
        inst_n[ACC_B]  = 1'b1;
        inst_n[CENP_B] = 1'b0;
        inst_n[AP_HI:AP_LO] = acc_a;
        step = 1'b1;
        if (cnt == 7'(len_kij - 1)) begin
          cnt_n   = '0;
          state_n = AC_WR;
        end else begin
          cnt_n = cnt + 7'd1;
        end
      end
      AC_WR: begin
        inst_n[CENP_B] = 1'b0;
        inst_n[WENP_B] = 1'b0;
        inst_n[AP_HI:AP_LO] = out_base + 11'(o);
        if (o == 5'(len_onij - 1)) begin
          state_n = DONE;
        end else begin
          o_n     = o + 5'd1;
          state_n = AC_RD;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.inst = inst;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl: stimulus queues the expected
// non-NOP instruction stream, a negedge monitor pops and compares.
module tb_core_ctrl;

  localparam logic [33:0] NOP = 34'h1800C0000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  core_ctrl_if bus();

  core_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [33:0] exp_q[$];
  logic [33:0] trace[$];
  int total = 0;
  int bad = 0;
  int busy_cyc = 0;
  int done_cnt = 0;
  bit prev_v = 1'b0;
  int t0, b0, d0;
  int o5[9] = '{7, 44, 81, 121, 158, 195, 235, 272, 309};

  task automatic chk(input string nm, input logic [33:0] got,
                     input logic [33:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic push_layer();
    logic [33:0] e;
    for (int kij = 0; kij < 9; kij++) begin
      for (int c = 0; c < 8; c++) begin
        e = NOP; e[19] = 1'b0; e[2] = 1'b1;
        e[17:7] = 11'(1024 + kij * 8 + c);
        exp_q.push_back(e);
      end
      for (int c = 0; c < 8; c++) begin
        e = NOP; e[3] = 1'b1; e[0] = 1'b1;
        exp_q.push_back(e);
      end
      for (int c = 0; c < 36; c++) begin
        e = NOP; e[19] = 1'b0; e[2] = 1'b1;
        e[17:7] = 11'(c);
        exp_q.push_back(e);
      end
      for (int c = 0; c < 36; c++) begin
        e = NOP; e[3] = 1'b1; e[1] = 1'b1;
        exp_q.push_back(e);
      end
      for (int c = 0; c < 36; c++) begin
        e = NOP; e[6] = 1'b1; e[32] = 1'b0; e[31] = 1'b0;
        e[30:20] = 11'(kij * 36 + c);
        exp_q.push_back(e);
      end
    end
    for (int o = 0; o < 16; o++) begin
      for (int kr = 0; kr < 3; kr++) begin
        for (int kc = 0; kc < 3; kc++) begin
          e = NOP; e[33] = 1'b1; e[32] = 1'b0;
          e[30:20] = 11'((kr * 3 + kc) * 36
                   + (o / 4 + kr) * 6 + (o % 4) + kc);
          exp_q.push_back(e);
        end
      end
      e = NOP; e[32] = 1'b0; e[31] = 1'b0;
      e[30:20] = 11'(512 + o);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int d, input int lim,
                           input bit tog);
    int c = 0;
    while (done_cnt == d && c < lim) begin
      @(posedge clk); #1;
      if (tog) bus.ofifo_valid = ~bus.ofifo_valid;
      c++;
    end
    if (done_cnt == d) begin
      total++; bad++;
      $display("FAIL done_timeout got=none want=done");
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        prev_v = 1'b0;
      end else begin
        if (bus.busy && !bus.done) busy_cyc++;
        if (bus.done) done_cnt++;
        if (bus.inst[6])
          chk("rd_on_valid", 34'(prev_v), 34'd1);
        if (bus.inst !== NOP) begin
          trace.push_back(bus.inst);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_inst got=%h want=none",
                     bus.inst);
          end else begin
            chk($sformatf("inst%0d", trace.size() - 1),
                bus.inst, exp_q.pop_front());
          end
        end
        prev_v = bus.ofifo_valid;
      end
    end
  end

  initial begin
    int c;
    bus.start = 1'b0;
    bus.ofifo_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_inst", bus.inst, NOP);
    chk("rst_busy", 34'(bus.busy), 34'd0);
    chk("rst_done", 34'(bus.done), 34'd0);
    reset = 1'b0;

    // Run 1: valid tied high, stray start while busy
    push_layer();
    t0 = trace.size(); b0 = busy_cyc; d0 = done_cnt;
    @(posedge clk);
    #1 chk("idle_busy", 34'(bus.busy), 34'd0);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("busy_rise", 34'(bus.busy), 34'd1);
    repeat (300) @(posedge clk);
    pulse_start();
    wait_done(d0, 3000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_cycles", 34'(busy_cyc - b0), 34'd1420);
    chk("done_pulses", 34'(done_cnt - d0), 34'd1);
    chk("drain1", 34'(exp_q.size()), 34'd0);
    chk("idle_after", 34'(bus.busy), 34'd0);
    for (int i = 0; i < 8; i++)
      chk("kij2_w", 34'({trace[t0+248+i][2],
          trace[t0+248+i][17:7]}), 34'({1'b1, 11'(1040 + i)}));
    for (int i = 0; i < 36; i++)
      chk("kij2_x", 34'({trace[t0+264+i][2],
          trace[t0+264+i][17:7]}), 34'({1'b1, 11'(i)}));
    for (int i = 0; i < 36; i++)
      chk("kij2_p", 34'({trace[t0+336+i][6],
          trace[t0+336+i][31], trace[t0+336+i][30:20]}),
          34'({2'b10, 11'(72 + i)}));
    for (int j = 0; j < 9; j++)
      chk("o5_rd", 34'({trace[t0+1166+j][33],
          trace[t0+1166+j][31], trace[t0+1166+j][30:20]}),
          34'({2'b11, 11'(o5[j])}));
    chk("o5_wr", 34'({trace[t0+1175][33],
        trace[t0+1175][32], trace[t0+1175][31],
        trace[t0+1175][30:20]}), 34'({3'b000, 11'd517}));

    // Run 2: ofifo_valid toggles every cycle
    push_layer();
    d0 = done_cnt;
    pulse_start();
    wait_done(d0, 6000, 1'b1);
    bus.ofifo_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses2", 34'(done_cnt - d0), 34'd1);
    chk("drain2", 34'(exp_q.size()), 34'd0);

    // Run 3: reset during X_EX of kij=4, then restart
    push_layer();
    t0 = trace.size();
    pulse_start();
    c = 0;
    while (trace.size() < t0 + 560 && c < 2000) begin
      @(posedge clk); c++;
    end
    if (trace.size() < t0 + 560) begin
      total++; bad++;
      $display("FAIL reach_xex got=%0d want=%0d",
               trace.size() - t0, 560);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_inst", bus.inst, NOP);
    chk("mid_rst_busy", 34'(bus.busy), 34'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    push_layer();
    t0 = trace.size(); b0 = busy_cyc; d0 = done_cnt;
    pulse_start();
    wait_done(d0, 3000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("restart_first", 34'({trace[t0][2],
        trace[t0][17:7]}), 34'({1'b1, 11'd1024}));
    chk("busy_cycles3", 34'(busy_cyc - b0), 34'd1420);
    chk("done_pulses3", 34'(done_cnt - d0), 34'd1);
    chk("drain3", 34'(exp_q.size()), 34'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
